// File: rtl/sbox_layer_serial.sv
// Serialised 4-bit S-box layer: LANES nibbles substituted per clock.
// Optional inverse table and inv port when SBOX_INVERSE_EN is defined.
module sbox_layer_serial #(
  parameter int NIBBLES = 16,
  parameter int LANES   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef SBOX_INVERSE_EN
  input  logic                 inv,
`endif
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] out_data,
  output logic                 busy
);

  localparam int GROUPS = NIBBLES / LANES;
  localparam int CW = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  if (NIBBLES % LANES != 0) begin : g_chk
    $error("NIBBLES must be a multiple of LANES");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic [4*NIBBLES-1:0] st_q, sub;
  logic                last;

  function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
    logic [3:0] y;
    unique case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

`ifdef SBOX_INVERSE_EN
  logic inv_q;

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    logic [3:0] y;
    unique case (x)
      4'h0: y = 4'h5;
      4'h1: y = 4'hE;
      4'h2: y = 4'hF;
      4'h3: y = 4'h8;
      4'h4: y = 4'hC;
      4'h5: y = 4'h1;
      4'h6: y = 4'h2;
      4'h7: y = 4'hD;
      4'h8: y = 4'hB;
      4'h9: y = 4'h4;
      4'hA: y = 4'h6;
      4'hB: y = 4'h3;
      4'hC: y = 4'h0;
      4'hD: y = 4'h7;
      4'hE: y = 4'h9;
      default: y = 4'hA;
    endcase
    return y;
  endfunction
`endif

  assign last = (cnt_q == CW'(GROUPS - 1));

  // Substitute only the current group; other nibbles pass through
  always_comb begin
    int idx;
    sub = st_q;
    idx = 0;
    for (int l = 0; l < LANES; l++) begin
      idx = int'(cnt_q) * LANES + l;
`ifdef SBOX_INVERSE_EN
      sub[idx*4 +: 4] = inv_q ? sbox_inv(st_q[idx*4 +: 4])
                              : sbox_fwd(st_q[idx*4 +: 4]);
`else
      sub[idx*4 +: 4] = sbox_fwd(st_q[idx*4 +: 4]);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= '0;
      cnt_q <= '0;
`ifdef SBOX_INVERSE_EN
      inv_q <= 1'b0;
`endif
    end else if (state_q == IDLE && in_valid) begin
      st_q  <= in_data;
      cnt_q <= '0;
`ifdef SBOX_INVERSE_EN
      inv_q <= inv;
`endif
    end else if (state_q == BUSY) begin
      st_q  <= sub;
      cnt_q <= last ? '0 : cnt_q + 1'b1;
    end
  end

  assign out_data = st_q;

endmodule
